regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
//  Multi-cycle write-back sequencer for the register file. Accepts one decoded instruction at a
//  time and waits for the ALU result (dr2). For LD/ST it runs the memory handshake; LD loads mdr.
//  Then it issues a single-cycle register-file write and selects dr2 (ALU) or mdr (LD) as the source.
//  Sits between decode and the regfile write-data mux; it owns rf_we and the mdr load enable.
// PARAMETERS
//  REG_ADDR_W   5   register index width
//  MEM_TIMEOUT  16  max MEM-state cycles waiting for mem_ack; 0 = no timeout
// PORTS
//  clk          in   1           clock, all state on rising edge
//  rst          in   1           synchronous, active-high reset
//  issue_valid  in   1           decoded instruction offered
//  issue_ready  out  1           controller idle, instruction accepted when valid&ready
//  op1          in   8           opcode field 1 (sampled on accept)
//  op2          in   2           opcode field 2 (sampled on accept)
//  op3          in   3           opcode field 3 (sampled on accept)
//  rd           in   REG_ADDR_W  destination register (sampled on accept)
//  alu_done     in   1           dr2 holds the result/effective address this cycle
//  mem_req      out  1           memory access request, held until mem_ack or timeout
//  mem_we       out  1           1 = store, 0 = load; valid while mem_req
//  mem_ack      in   1           memory completes the access; load data valid this cycle
//  mdr_we       out  1           load mdr from memory read data (1-cycle pulse)
//  rf_we        out  1           register-file write enable (1-cycle pulse)
//  rf_waddr     out  REG_ADDR_W  register-file write index
//  rf_wsel      out  1           0 = dr2, 1 = mdr
//  retire       out  1           instruction complete (1-cycle pulse)
//  mem_err      out  1           sticky: memory timeout occurred
// BEHAVIOUR
//  Class decode on accept ({op1,op2,op3} casex): `zLD -> LOAD; `zST -> STORE; else -> ALU.
//  States: IDLE, EXEC, MEM, WB.
//   IDLE: issue_ready=1. If issue_valid, latch class and rd -> EXEC.
//   EXEC: wait for alu_done. ALU -> WB; LOAD/STORE -> MEM (mem_req rises next cycle).
//   MEM : mem_req=1, mem_we=(STORE), wait counter increments each cycle.
//         If mem_ack: LOAD -> mdr_we=1 this cycle, -> WB. STORE -> retire=1 this cycle, -> IDLE.
//         If no ack and counter==MEM_TIMEOUT-1: mem_err<=1, -> IDLE, no write-back, no retire.
//   WB  : rf_we=(rd!=0), rf_waddr=rd, rf_wsel=(LOAD), retire=1 -> IDLE.
//  Latency: ALU instruction accepted at cycle 0 with alu_done at 1 -> rf_we at 2.
//   LOAD: mem_ack at cycle t -> mdr_we at t, rf_we at t+1 (mdr is stable by then).
//  Outputs are registered state decodes; rf_waddr/rf_wsel are 0 outside WB.
//  Boundaries:
//   - mem_ack in the final timeout cycle: ack wins; no error.
//   - rd==0: r0 is hard-wired; rf_we stays 0, but retire still pulses.
//   - issue_valid while busy: ignored (issue_ready=0, nothing latched).
//   - alu_done outside EXEC and mem_ack outside MEM: ignored.
//   - mem_err clears only on rst and does not block later issues.
//   - MEM_TIMEOUT=0: MEM waits indefinitely.
//  Reset (including mid-operation): next edge -> IDLE, counter=0, mem_err=0.
//   All outputs 0 except issue_ready=1. An in-flight mem_req drops and a pending write is discarded.
// STRUCTURE
//  defines.vh (shared): `zLD/`zST opcode patterns, state encodings `WB_IDLE..`WB_WB, class codes.
//  The class decode function follows the same casex on {op1,op2,op3} as the regfile write mux.
//  Sub-module: wb_mem_timer (clear/enable/expire counter, width $clog2(MEM_TIMEOUT+1)).
// TESTING
//  1 ALU op, rd=3, alu_done 1 cycle after accept -> rf_we=1, rf_waddr=3, rf_wsel=0 exactly 2 cycles after accept.
//  2 LD, rd=7, mem_ack 4 cycles after mem_req -> mdr_we with ack, next cycle rf_we=1, rf_wsel=1, waddr=7.
//  3 ST, mem_ack after 2 cycles -> mem_we=1 throughout MEM, retire with ack, rf_we never asserts.
//  4 LD, MEM_TIMEOUT=16, no ack -> mem_req high exactly 16 cycles, then mem_err=1, no rf_we, issue_ready=1.
//  5 Ack in the 16th cycle -> no mem_err. LD to rd=0 -> retire=1 with rf_we=0.
//  6 rst during MEM; issue_valid while in EXEC -> all outputs clear next edge; busy-time offer never latched.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types for the register-file write-back sequencer: FSM states,
// instruction classes and the opcode class decode.
package regfile_wb_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_EXEC = 2'd1,
    WB_MEM  = 2'd2,
    WB_WB   = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } wb_class_e;

  // Same pattern match as the regfile write-data mux; op2 is a don't-care for LD/ST.
  function automatic wb_class_e decode_class(input logic [7:0] op1,
                                             input logic [1:0] op2,
                                             input logic [2:0] op3);
    wb_class_e cls;
    cls = CLS_ALU;
    casez ({op1, op2, op3})
      13'b0000_0011_??_010: cls = CLS_LOAD;
      13'b0010_0011_??_010: cls = CLS_STORE;
      default:              cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_mem_timer.sv
// MEM-state wait counter: cleared outside MEM, flags the final allowed cycle.
module wb_mem_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout never expires, so MEM waits for the ack indefinitely.
  assign expire = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Multi-cycle write-back sequencer: waits for the ALU result, runs the memory
// handshake for LD/ST and issues a single-cycle register-file write.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [7:0]            op1,
  input  logic [1:0]            op2,
  input  logic [2:0]            op3,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  alu_done,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  mdr_we,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic                  rf_wsel,
  output logic                  retire,
  output logic                  mem_err
);

  wb_state_e             state_q, state_d;
  wb_class_e             cls_q, cls_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  mem_err_q, mem_err_d;
  logic                  tmr_clr;
  logic                  tmr_en;
  logic                  tmr_expire;

  wb_mem_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    rd_d        = rd_q;
    mem_err_d   = mem_err_q;
    issue_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mdr_we      = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wsel     = 1'b0;
    retire      = 1'b0;
    tmr_en      = 1'b0;
    tmr_clr     = (state_q != WB_MEM);

    unique case (state_q)
      WB_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          cls_d   = decode_class(op1, op2, op3);
          rd_d    = rd;
          state_d = WB_EXEC;
        end
      end
      WB_EXEC: begin
        if (alu_done) begin
          state_d = (cls_q == CLS_ALU) ? WB_WB : WB_MEM;
        end
      end
      WB_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        tmr_en  = 1'b1;
        // An ack in the final timeout cycle takes priority over the timeout.
        if (mem_ack) begin
          if (cls_q == CLS_LOAD) begin
            mdr_we  = 1'b1;
            state_d = WB_WB;
          end else begin
            retire  = 1'b1;
            state_d = WB_IDLE;
          end
        end else if (tmr_expire) begin
          mem_err_d = 1'b1;
          state_d   = WB_IDLE;
        end
      end
      WB_WB: begin
        rf_we    = (rd_q != '0);
        rf_waddr = rd_q;
        rf_wsel  = (cls_q == CLS_LOAD);
        retire   = 1'b1;
        state_d  = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      cls_q     <= CLS_ALU;
      rd_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      rd_q      <= rd_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: ALU, load, store, timeout, r0 and reset cases.
module tb_regfile_wb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] op1;
  logic [1:0] op2;
  logic [2:0] op3;
  logic [4:0] rd;
  logic       alu_done;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic       mdr_we;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       rf_wsel;
  logic       retire;
  logic       mem_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  localparam logic [7:0] OP1_LD  = 8'h03;
  localparam logic [7:0] OP1_ST  = 8'h23;
  localparam logic [7:0] OP1_ALU = 8'h33;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .op1        (op1),
    .op2        (op2),
    .op3        (op3),
    .rd         (rd),
    .alu_done   (alu_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wsel    (rf_wsel),
    .retire     (retire),
    .mem_err    (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Packed snapshot: {issue_ready, mem_req, mem_we, mdr_we, rf_we, rf_wsel, retire, mem_err, rf_waddr}
  function automatic logic [12:0] outs();
    return {issue_ready, mem_req, mem_we, mdr_we, rf_we, rf_wsel, retire, mem_err, rf_waddr};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [7:0] o1, input logic [2:0] o3, input logic [4:0] r);
    issue_valid = 1'b1;
    op1 = o1;
    op2 = 2'b10;
    op3 = o3;
    rd  = r;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    alu_done = 1'b0;
    mem_ack = 1'b0;
    op1 = '0;
    op2 = '0;
    op3 = '0;
    rd = '0;
  endtask

  initial begin
    int unsigned req_cycles;
    logic        saw_rf_we;
    logic        saw_req;

    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    settle();
    check("reset_outputs", 32'(outs()), 32'h1000);

    // alu_done and mem_ack while idle are ignored
    alu_done = 1'b1;
    mem_ack = 1'b1;
    next_cycle();
    idle_inputs();
    settle();
    check("stray_inputs_idle", 32'(outs()), 32'h1000);

    // Test 1: ALU rd=3; busy-time offer rd=9 in EXEC must not be latched
    offer(OP1_ALU, 3'b000, 5'd3);
    settle();
    check("t1_ready_accept", 32'(issue_ready), 32'd1);
    next_cycle();
    offer(OP1_LD, 3'b010, 5'd9);
    alu_done = 1'b1;
    settle();
    check("t1_exec_busy", 32'(outs()), 32'h0000);
    next_cycle();
    idle_inputs();
    settle();
    check("t1_wb", 32'(outs()), {19'd0, 8'b0000_1010, 5'd3});
    next_cycle();
    settle();
    check("t1_back_idle", 32'(outs()), 32'h1000);

    // Test 2: LD rd=7, ack on the 5th MEM cycle (4 cycles after mem_req rises)
    offer(OP1_LD, 3'b010, 5'd7);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (mem_req === 1'b1 && mem_we === 1'b0 && mdr_we === 1'b0) req_cycles++;
      next_cycle();
    end
    check("t2_mem_wait", 32'(req_cycles), 32'd4);
    mem_ack = 1'b1;
    settle();
    check("t2_ack_mdr_we", 32'(outs()), {19'd0, 8'b0101_0000, 5'd0});
    next_cycle();
    mem_ack = 1'b0;
    settle();
    check("t2_wb", 32'(outs()), {19'd0, 8'b0000_1110, 5'd7});
    next_cycle();

    // Test 3: ST, ack after 2 MEM cycles; no register write
    offer(OP1_ST, 3'b010, 5'd12);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    settle();
    check("t3_mem_c0", 32'(outs()), {19'd0, 8'b0110_0000, 5'd0});
    next_cycle();
    settle();
    check("t3_mem_c1", 32'(outs()), {19'd0, 8'b0110_0000, 5'd0});
    next_cycle();
    mem_ack = 1'b1;
    settle();
    check("t3_ack_retire", 32'(outs()), {19'd0, 8'b0110_0010, 5'd0});
    next_cycle();
    mem_ack = 1'b0;
    settle();
    check("t3_idle_no_wb", 32'(outs()), 32'h1000);

    // Test 4: LD with no ack -> 16 mem_req cycles then sticky mem_err
    offer(OP1_LD, 3'b010, 5'd5);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    req_cycles = 0;
    saw_rf_we = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (rf_we === 1'b1) saw_rf_we = 1'b1;
      if (mem_req === 1'b1) begin
        saw_req = 1'b1;
        req_cycles++;
      end else if (saw_req) begin
        break;
      end
      next_cycle();
    end
    check("t4_req_cycles", 32'(req_cycles), 32'd16);
    check("t4_no_rf_we", 32'(saw_rf_we), 32'd0);
    check("t4_after_timeout", 32'(outs()), {19'd0, 8'b1000_0001, 5'd0});

    // mem_err does not block a later ALU issue
    offer(OP1_ALU, 3'b001, 5'd2);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    settle();
    check("t4_wb_with_err", 32'(outs()), {19'd0, 8'b0000_1011, 5'd2});
    next_cycle();

    // Reset clears mem_err
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    check("t5_reset_clears_err", 32'(outs()), 32'h1000);

    // Test 5a: ack in the 16th MEM cycle wins over the timeout
    offer(OP1_LD, 3'b010, 5'd6);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    for (int i = 0; i < 15; i++) next_cycle();
    mem_ack = 1'b1;
    settle();
    check("t5_last_cycle_ack", 32'(outs()), {19'd0, 8'b0101_0000, 5'd0});
    next_cycle();
    mem_ack = 1'b0;
    settle();
    check("t5_wb_no_err", 32'(outs()), {19'd0, 8'b0000_1110, 5'd6});
    next_cycle();

    // Test 5b: LD to r0 retires without a register write
    offer(OP1_LD, 3'b010, 5'd0);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    mem_ack = 1'b1;
    next_cycle();
    mem_ack = 1'b0;
    settle();
    check("t5_r0_retire", 32'(outs()), {19'd0, 8'b0000_0110, 5'd0});
    next_cycle();

    // Test 6: reset during MEM drops the request and discards the write
    offer(OP1_LD, 3'b010, 5'd4);
    next_cycle();
    idle_inputs();
    alu_done = 1'b1;
    next_cycle();
    alu_done = 1'b0;
    next_cycle();
    rst = 1'b1;
    settle();
    check("t6_mem_before_rst", 32'(mem_req), 32'd1);
    next_cycle();
    rst = 1'b0;
    mem_ack = 1'b1;
    settle();
    check("t6_after_rst", 32'(outs()), 32'h1000);
    next_cycle();
    mem_ack = 1'b0;
    settle();
    check("t6_stays_idle", 32'(outs()), 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 20000");
    $fatal(1, "watchdog timeout");
  end

endmodule
